// File: rtl/pixchk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pixchk_pkg
//  Description : Shared types for the pixel stream checker: the line/frame
//                tracking state encoding, the 16-bit counter type and a byte
//                masking helper used by the frame checksum.
//  Revision    : 1.0  initial release
// ============================================================================
package pixchk_pkg;

  typedef enum logic [1:0] {
    WAIT_SOF  = 2'd0,
    IN_LINE   = 2'd1,
    DRAIN_EOL = 2'd2
  } state_t;

  typedef logic [15:0] cnt16_t;

  localparam cnt16_t C_CNT_MAX = 16'hFFFF;

  // Zero every byte of data whose keep bit is clear.
  function automatic logic [31:0] keep_mask(input logic [31:0] data,
                                            input logic [3:0]  keep);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = keep[i] ? data[8*i +: 8] : 8'h00;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixchk_prbs.sv
`default_nettype none
// ============================================================================
//  Module      : pixchk_prbs
//  Description : 33-bit PRBS generator advancing every clock; its MSB gates
//                the checker's tready when the PRBS ready option is built in.
//  Ports       : clk      - clock, rising edge
//                rst      - asynchronous active-high reset, loads RND_SEED
//                prbs_msb - current bit 32 of the sequence register
//  Revision    : 1.0  initial release
// ============================================================================
module pixchk_prbs #(
  parameter logic [32:0] RND_SEED = 33'h04A4C3F8A
) (
  input  logic clk,
  input  logic rst,
  output logic prbs_msb
);

  logic [32:0] r_prbs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prbs <= RND_SEED;
    end else begin
      r_prbs <= {r_prbs[31:0], r_prbs[32] ^~ r_prbs[19]};
    end
  end

  assign prbs_msb = r_prbs[32];

endmodule
`default_nettype wire

// File: rtl/pixel_stream_checker.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_stream_checker
//  Description : AXI-Stream video framing checker. Tracks word/line position
//                against X_SIZE x Y_SIZE, flags start-of-frame, end-of-line
//                and idle timeout errors (sticky), counts frames and error
//                events, and reports a checksum with a one-cycle frame_done
//                pulse after each cleanly terminated frame.
//  Ports       : in_stream_aclk / axi_reset  - clock, async active-high reset
//                in_stream_t*                - AXI-Stream slave (tready is
//                                              registered)
//                ready_en                    - allows tready next cycle
//                clear                       - sync clear of counters/flags
//                frame_count, err_count      - 16-bit counters
//                err_sof/err_eol/err_timeout - sticky error flags
//                frame_done, frame_sum       - completion pulse + checksum
//  Options     : PIXCHK_PRBS_READY_EN - when defined, tready is additionally
//                gated by a 33-bit PRBS (pixchk_prbs) seeded with RND_SEED.
//  Revision    : 1.0  initial release
// ============================================================================
module pixel_stream_checker
  import pixchk_pkg::*;
#(
  parameter int          X_SIZE   = 384,
  parameter int          Y_SIZE   = 512,
  parameter int          TIMEOUT  = 10000,
  parameter logic [32:0] RND_SEED = 33'h04A4C3F8A
) (
  input  logic        in_stream_aclk,
  input  logic        axi_reset,
  input  logic [31:0] in_stream_tdata,
  input  logic [3:0]  in_stream_tkeep,
  input  logic        in_stream_tvalid,
  input  logic        in_stream_tuser,
  input  logic        in_stream_tlast,
  output logic        in_stream_tready,
  input  logic        ready_en,
  input  logic        clear,
  output logic [15:0] frame_count,
  output logic        err_sof,
  output logic        err_eol,
  output logic        err_timeout,
  output logic [15:0] err_count,
  output logic        frame_done,
  output logic [31:0] frame_sum
);

  localparam logic [11:0] C_X_LAST = 12'(X_SIZE - 1);
  localparam logic [11:0] C_Y_LAST = 12'(Y_SIZE - 1);
  localparam int          C_TO_W   = $clog2(TIMEOUT);
  localparam logic [C_TO_W-1:0] C_TO_LAST = C_TO_W'(TIMEOUT - 1);

  state_t              r_state;
  logic [11:0]         r_x, r_y;
  logic [31:0]         r_sum, r_frame_sum;
  logic                r_tready, r_frame_done;
  logic                r_err_sof, r_err_eol, r_err_to;
  cnt16_t              r_fc, r_ec;
  logic [C_TO_W-1:0]   r_to_cnt;

  state_t              w_state_nxt;
  logic [11:0]         w_x_nxt, w_y_nxt, w_ex, w_ey;
  logic [31:0]         w_sum_nxt, w_masked;
  logic                w_beat, w_sof, w_err_sof, w_err_eol, w_done;
  logic                w_in_line, w_line_end, w_line_good;
  logic                w_to_evt, w_ready_nxt;
  logic [C_TO_W-1:0]   w_to_nxt;
  logic [16:0]         w_ec_sum;
  cnt16_t              w_ec_nxt;

  assign w_beat   = in_stream_tvalid && r_tready;
  assign w_masked = keep_mask(in_stream_tdata, in_stream_tkeep);

`ifdef PIXCHK_PRBS_READY_EN
  logic w_prbs_msb;

  pixchk_prbs #(
    .RND_SEED (RND_SEED)
  ) u_prbs (
    .clk      (in_stream_aclk),
    .rst      (axi_reset),
    .prbs_msb (w_prbs_msb)
  );

  assign w_ready_nxt = ready_en && w_prbs_msb;
`else
  logic w_unused_seed;
  assign w_unused_seed = ^RND_SEED;
  assign w_ready_nxt   = ready_en;
`endif

  // Frame position tracking. A tuser beat always (re)starts a frame and is
  // then treated as word 0 of line 0, so its tlast is judged like any word.
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_sum_nxt   = r_sum;
    w_ex        = r_x;
    w_ey        = r_y;
    w_sof       = 1'b0;
    w_err_sof   = 1'b0;
    w_err_eol   = 1'b0;
    w_done      = 1'b0;
    w_in_line   = 1'b0;
    w_line_end  = 1'b0;
    w_line_good = 1'b0;

    if (w_beat) begin
      if (in_stream_tuser) begin
        w_sof     = 1'b1;
        w_err_sof = (r_state != WAIT_SOF) &&
                    !(r_state == IN_LINE && r_x == '0 && r_y == '0);
        w_ex      = '0;
        w_ey      = '0;
        w_sum_nxt = w_masked;
        w_in_line = 1'b1;
      end else begin
        case (r_state)
          WAIT_SOF:  w_err_sof = 1'b1;
          IN_LINE: begin
            w_sum_nxt = r_sum + w_masked;
            w_in_line = 1'b1;
          end
          DRAIN_EOL: w_line_end = in_stream_tlast;
          default:   w_state_nxt = WAIT_SOF;
        endcase
      end

      if (w_in_line) begin
        if (w_ex == C_X_LAST) begin
          if (in_stream_tlast) begin
            w_line_end  = 1'b1;
            w_line_good = 1'b1;
          end else begin
            w_err_eol   = 1'b1;
            w_x_nxt     = w_ex;
            w_y_nxt     = w_ey;
            w_state_nxt = DRAIN_EOL;
          end
        end else if (in_stream_tlast) begin
          w_err_eol  = 1'b1;
          w_line_end = 1'b1;
        end else begin
          w_x_nxt     = w_ex + 12'd1;
          w_y_nxt     = w_ey;
          w_state_nxt = IN_LINE;
        end
      end

      // Only a correctly terminated last line reports completion.
      if (w_line_end) begin
        w_x_nxt = '0;
        if (w_ey == C_Y_LAST) begin
          w_y_nxt     = '0;
          w_state_nxt = WAIT_SOF;
          w_done      = w_line_good;
        end else begin
          w_y_nxt     = w_ey + 12'd1;
          w_state_nxt = IN_LINE;
        end
      end
    end
  end

  // Idle timeout: any tvalid cycle restarts the count.
  assign w_to_evt = !in_stream_tvalid && (r_to_cnt == C_TO_LAST);
  assign w_to_nxt = (in_stream_tvalid || w_to_evt) ? '0 : r_to_cnt + C_TO_W'(1);

  // Up to two events can land in one cycle; saturate at all-ones.
  assign w_ec_sum = {1'b0, r_ec} + 17'(w_err_sof) + 17'(w_err_eol) + 17'(w_to_evt);
  assign w_ec_nxt = w_ec_sum[16] ? C_CNT_MAX : w_ec_sum[15:0];

  always_ff @(posedge in_stream_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      r_state      <= WAIT_SOF;
      r_x          <= '0;
      r_y          <= '0;
      r_sum        <= '0;
      r_tready     <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_sum  <= '0;
      r_fc         <= '0;
      r_ec         <= '0;
      r_err_sof    <= 1'b0;
      r_err_eol    <= 1'b0;
      r_err_to     <= 1'b0;
      r_to_cnt     <= '0;
    end else begin
      r_tready     <= w_ready_nxt;
      r_state      <= w_state_nxt;
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_sum        <= w_sum_nxt;
      r_frame_done <= w_done;
      if (w_done) begin
        r_frame_sum <= w_sum_nxt;
      end
      if (clear) begin
        r_fc      <= '0;
        r_ec      <= '0;
        r_err_sof <= 1'b0;
        r_err_eol <= 1'b0;
        r_err_to  <= 1'b0;
        r_to_cnt  <= '0;
      end else begin
        if (w_sof)     r_fc      <= r_fc + 16'd1;
        if (w_err_sof) r_err_sof <= 1'b1;
        if (w_err_eol) r_err_eol <= 1'b1;
        if (w_to_evt)  r_err_to  <= 1'b1;
        r_ec     <= w_ec_nxt;
        r_to_cnt <= w_to_nxt;
      end
    end
  end

  assign in_stream_tready = r_tready;
  assign frame_count      = r_fc;
  assign err_sof          = r_err_sof;
  assign err_eol          = r_err_eol;
  assign err_timeout      = r_err_to;
  assign err_count        = r_ec;
  assign frame_done       = r_frame_done;
  assign frame_sum        = r_frame_sum;

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_stream_checker
//  Description : Self-checking bench for pixel_stream_checker (4x2 frames).
//                A frame-level reference model predicts every output each
//                cycle; directed sequences plus randomized traffic.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pixel_stream_checker;

  localparam int X  = 4;
  localparam int Y  = 2;
  localparam int TO = 10000;

  logic        clk = 1'b0;
  logic        axi_reset = 1'b1;
  logic [31:0] tdata = '0;
  logic [3:0]  tkeep = '0;
  logic        tvalid = 1'b0, tuser = 1'b0, tlast = 1'b0;
  logic        ready_en = 1'b0, clear = 1'b0;
  logic        tready, err_sof, err_eol, err_timeout, frame_done;
  logic [15:0] frame_count, err_count;
  logic [31:0] frame_sum;

  always #5 clk = ~clk;

  pixel_stream_checker #(
    .X_SIZE (X),
    .Y_SIZE (Y),
    .TIMEOUT(TO)
  ) dut (
    .in_stream_aclk  (clk),
    .axi_reset       (axi_reset),
    .in_stream_tdata (tdata),
    .in_stream_tkeep (tkeep),
    .in_stream_tvalid(tvalid),
    .in_stream_tuser (tuser),
    .in_stream_tlast (tlast),
    .in_stream_tready(tready),
    .ready_en        (ready_en),
    .clear           (clear),
    .frame_count     (frame_count),
    .err_sof         (err_sof),
    .err_eol         (err_eol),
    .err_timeout     (err_timeout),
    .err_count       (err_count),
    .frame_done      (frame_done),
    .frame_sum       (frame_sum)
  );

  int n_checks = 0;
  int n_errors = 0;
  int dut_dones = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_FRAME, M_DRAIN} mmode_e;
  mmode_e      m_mode;
  int          m_word, m_line, m_idle;
  logic        m_tready, m_esof, m_eeol, m_eto, m_done, m_beat;
  logic [15:0] m_fc, m_ec;
  logic [31:0] m_sum, m_fsum;
  logic [32:0] m_prbs;

  function automatic logic [31:0] masked(input logic [31:0] d, input logic [3:0] k);
    logic [31:0] s;
    s = 0;
    for (int i = 0; i < 4; i++)
      if (k[i]) s = s + ((d >> (8 * i)) & 32'hFF) * (32'h1 << (8 * i));
    return s;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_word = 0; m_line = 0; m_idle = 0;
    m_tready = 0; m_esof = 0; m_eeol = 0; m_eto = 0; m_done = 0; m_beat = 0;
    m_fc = 0; m_ec = 0; m_sum = 0; m_fsum = 0;
    m_prbs = 33'h04A4C3F8A;
  endtask

  task automatic next_line(input bit good);
    m_word = 0;
    if (m_line == Y - 1) begin
      m_line = 0;
      m_mode = M_IDLE;
      if (good) begin
        m_done = 1;
        m_fsum = m_sum;
      end
    end else begin
      m_line++;
      m_mode = M_FRAME;
    end
  endtask

  task automatic place_word(output int e);
    e = 0;
    if (m_word == X - 1) begin
      if (tlast) next_line(1);
      else begin e = 1; m_eeol = 1; m_mode = M_DRAIN; end
    end else if (tlast) begin
      e = 1; m_eeol = 1; next_line(0);
    end else begin
      m_word++;
    end
  endtask

  task automatic model_edge();
    int ev, e, t;
    ev = 0;
    m_done = 0;
    m_beat = tvalid && m_tready;
    if (m_beat) begin
      if (tuser) begin
        if (m_mode != M_IDLE) begin ev++; m_esof = 1; end
        m_fc++;
        m_sum  = masked(tdata, tkeep);
        m_mode = M_FRAME; m_word = 0; m_line = 0;
        place_word(e); ev += e;
      end else if (m_mode == M_IDLE) begin
        ev++; m_esof = 1;
      end else if (m_mode == M_DRAIN) begin
        if (tlast) next_line(0);
      end else begin
        m_sum = m_sum + masked(tdata, tkeep);
        place_word(e); ev += e;
      end
    end
    if (tvalid) m_idle = 0;
    else begin
      m_idle++;
      if (m_idle == TO) begin m_idle = 0; ev++; m_eto = 1; end
    end
    t = int'(m_ec) + ev;
    m_ec = (t > 65535) ? 16'hFFFF : 16'(t);
    if (clear) begin
      m_fc = 0; m_ec = 0; m_esof = 0; m_eeol = 0; m_eto = 0; m_idle = 0;
    end
`ifdef PIXCHK_PRBS_READY_EN
    m_tready = ready_en && m_prbs[32];
    m_prbs   = {m_prbs[31:0], ~(m_prbs[32] ^ m_prbs[19])};
`else
    m_tready = ready_en;
`endif
  endtask

  task automatic compare();
    check("tready",      tready,      m_tready);
    check("frame_count", frame_count, m_fc);
    check("err_sof",     err_sof,     m_esof);
    check("err_eol",     err_eol,     m_eeol);
    check("err_timeout", err_timeout, m_eto);
    check("err_count",   err_count,   m_ec);
    check("frame_done",  frame_done,  m_done);
    check("frame_sum",   frame_sum,   m_fsum);
    if (frame_done) dut_dones++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  // Called just after a rising edge; reset asserts asynchronously.
  task automatic do_reset();
    axi_reset = 1;
    model_reset();
    #2;
    compare();
    @(posedge clk);
    #1;
    axi_reset = 0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic u, input logic l);
    int guard;
    guard = 0;
    tvalid = 1; tdata = d; tkeep = k; tuser = u; tlast = l;
    do begin
      cycle();
      guard++;
    end while (!m_beat && guard < 200);
    check("accept_bound", 32'(guard < 200), 32'd1);
    tvalid = 0; tuser = 0; tlast = 0;
  endtask

  task automatic send_frame(input logic [31:0] base, input logic [31:0] step, input logic [3:0] k);
    for (int i = 0; i < X * Y; i++)
      send_beat(base + step * i, k, i == 0, (i % X) == X - 1);
  endtask

  initial begin
    int d0, gword, gline;
    model_reset();
    #12;
    compare();
    @(posedge clk);
    #1;
    axi_reset = 0;

    // Reset state, then enable ready
    cycle();
    check("rst_fc", frame_count, 16'd0);
    ready_en = 1;
    cycle();

    // Two clean frames: 1..8 full keep, then 0x101 x8 with keep 1
    d0 = dut_dones;
    send_frame(32'd1, 32'd1, 4'hF);
    cycle();
    check("sum_1to8", frame_sum, 32'd36);
    send_frame(32'h0000_0101, 32'd0, 4'h1);
    cycle();
    check("sum_keep1", frame_sum, 32'd8);
    check("two_frames_fc", frame_count, 16'd2);
    check("two_frames_done", 32'(dut_dones - d0), 32'd2);
    check("two_frames_ec", err_count, 16'd0);

    // Early tlast on word 2 of line 0; next beat is line 1 word 0
    clear = 1; cycle(); clear = 0;
    d0 = dut_dones;
    send_beat(32'd1, 4'hF, 1, 0);
    send_beat(32'd2, 4'hF, 0, 0);
    send_beat(32'd3, 4'hF, 0, 1);
    check("early_eol_flag", err_eol, 1'b1);
    check("early_eol_cnt", err_count, 16'd1);
    for (int i = 0; i < X; i++) send_beat(32'd10 + i, 4'hF, 0, i == X - 1);
    cycle();
    check("line1_completes", 32'(dut_dones - d0), 32'd1);

    // tuser on word 3 of line 1 restarts the frame
    clear = 1; cycle(); clear = 0;
    d0 = dut_dones;
    for (int i = 0; i < X; i++) send_beat(32'd5, 4'hF, i == 0, i == X - 1);
    for (int i = 0; i < X - 1; i++) send_beat(32'd6, 4'hF, 0, 0);
    send_beat(32'd7, 4'hF, 1, 0);
    check("resync_sof", err_sof, 1'b1);
    check("resync_fc", frame_count, 16'd2);
    check("aborted_no_done", 32'(dut_dones - d0), 32'd0);
    for (int i = 1; i < X * Y; i++) send_beat(32'd8, 4'hF, 0, (i % X) == X - 1);
    cycle();
    check("resync_frame_done", 32'(dut_dones - d0), 32'd1);
    check("resync_ec", err_count, 16'd1);

    // Reset mid-frame: next beat without tuser is a start-of-frame error
    send_beat(32'd1, 4'hF, 1, 0);
    send_beat(32'd2, 4'hF, 0, 0);
    do_reset();
    check("midrst_fc", frame_count, 16'd0);
    cycle();
    send_beat(32'd3, 4'hF, 0, 0);
    check("post_rst_sof", err_sof, 1'b1);

    // Idle timeout
    clear = 1; cycle(); clear = 0;
    repeat (TO - 1) cycle();
    check("to_not_yet", err_timeout, 1'b0);
    cycle();
    check("to_flag", err_timeout, 1'b1);
    check("to_cnt", err_count, 16'd1);
    clear = 1; cycle(); clear = 0;
    check("clr_to", err_timeout, 1'b0);
    check("clr_ec", err_count, 16'd0);

    // Randomized traffic with occasional framing faults
    gword = 0; gline = 0;
    repeat (3000) begin
      ready_en = ($urandom_range(0, 9) != 0);
      clear    = ($urandom_range(0, 299) == 0);
      tvalid   = ($urandom_range(0, 9) < 8);
      tdata    = $urandom;
      tkeep    = 4'($urandom_range(0, 15));
      tuser    = (gword == 0 && gline == 0);
      tlast    = (gword == X - 1);
      if ($urandom_range(0, 39) == 0) tuser = ~tuser;
      if ($urandom_range(0, 39) == 0) tlast = ~tlast;
      cycle();
      if (m_beat) begin
        gword++;
        if (gword == X) begin gword = 0; gline = (gline + 1) % Y; end
      end
    end
    tvalid = 0; clear = 0; ready_en = 1;

    // A clean frame still completes after random traffic
    cycle();
    d0 = dut_dones;
    send_frame(32'd100, 32'd3, 4'hF);
    cycle();
    check("final_done", 32'(dut_dones - d0), 32'd1);
    check("final_sum", frame_sum, 32'd884);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
